// File: rtl/bmem_arbiter.sv
// Board-memory arbiter: VGA read fetch > board-clear sweeper > game engine on one BMEM port,
// with one-cycle read-return routing and sticky game starvation detection.
module bmem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 1600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_re,
    input  logic [ADDR_W-1:0] vga_raddr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    output logic              game_starved,
    input  logic              starve_clr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned       CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic {SERVE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] fill, fill_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] vga_hold, game_hold;
    logic              clear_own;
    logic              starve_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SERVE;
            ptr   <= '0;
            fill  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            fill  <= fill_nxt;
        end
    end

    // Port mux and sweep sequencing; reset forces the port idle so an aborted sweep writes nothing.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        fill_nxt  = fill;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        game_gnt  = 1'b0;
        clear_own = 1'b0;
        if (!reset) begin
            if (vga_re) begin
                mem_en   = 1'b1;
                mem_addr = vga_raddr;
            end else if (state == CLEAR) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = fill;
                clear_own = 1'b1;
            end else if (game_req) begin
                mem_en    = 1'b1;
                mem_we    = game_we;
                mem_addr  = game_addr;
                mem_wdata = game_wdata;
                game_gnt  = 1'b1;
            end
        end
        case (state)
            SERVE: begin
                if (clear_start) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                    fill_nxt  = clear_value;
                end
            end
            CLEAR: begin
                if (clear_own) begin
                    ptr_nxt = ptr + ADDR_W'(1);
                    if (ptr == PTR_LAST) begin
                        state_nxt = SERVE;
                    end
                end
            end
        endcase
    end

    assign clear_busy = (state == CLEAR);
    assign starve_set = game_req && !game_gnt && (wait_cnt == CNT_PRE);

    // Read-return owner tracking, rdata hold registers and starvation monitor.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rvalid   <= 1'b0;
            game_rvalid  <= 1'b0;
            vga_hold     <= '0;
            game_hold    <= '0;
            wait_cnt     <= '0;
            game_starved <= 1'b0;
        end else begin
            vga_rvalid  <= vga_re;
            game_rvalid <= game_gnt && !game_we;
            if (vga_rvalid) begin
                vga_hold <= mem_rdata;
            end
            if (game_rvalid) begin
                game_hold <= mem_rdata;
            end
            if (game_req && !game_gnt) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if (starve_set) begin
                game_starved <= 1'b1;
            end else if (starve_clr) begin
                game_starved <= 1'b0;
            end
        end
    end

    assign vga_rdata  = vga_rvalid  ? mem_rdata : vga_hold;
    assign game_rdata = game_rvalid ? mem_rdata : game_hold;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: behavioural BMEM stub plus a content model of the board.
module tb_bmem_arbiter;
    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned DEPTH        = 1024;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned STARVE_LIMIT = 1600;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vga_re = 1'b0;
    logic [ADDR_W-1:0] vga_raddr = '0;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              clear_start = 1'b0;
    logic [DATA_W-1:0] clear_value = '0;
    logic              clear_busy;
    logic              game_req = 1'b0;
    logic              game_we = 1'b0;
    logic [ADDR_W-1:0] game_addr = '0;
    logic [DATA_W-1:0] game_wdata = '0;
    logic              game_gnt;
    logic              game_rvalid;
    logic [DATA_W-1:0] game_rdata;
    logic              game_starved;
    logic              starve_clr = 1'b0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] bmem [DEPTH] = '{default: 8'h00};
    logic [DATA_W-1:0] model_mem [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    bmem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .vga_re(vga_re), .vga_raddr(vga_raddr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
        .game_gnt(game_gnt), .game_rvalid(game_rvalid), .game_rdata(game_rdata),
        .game_starved(game_starved), .starve_clr(starve_clr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bmem[mem_addr] <= mem_wdata;
            else        mem_rdata <= bmem[mem_addr];
        end
    end

    task automatic idle();
        vga_re = 1'b0; game_req = 1'b0; game_we = 1'b0; clear_start = 1'b0; starve_clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; vga_re = 1'b1; vga_raddr = 10'h055; game_req = 1'b1; game_we = 1'b1;
        game_addr = 10'h055; game_wdata = 8'hEE; clear_start = 1'b1;
        #1;
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en_in_reset: got %b want 0", mem_en); end
        n_cmp++; if (game_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt_in_reset: got %b want 0", game_gnt); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; idle();
        #1;
        n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rst_clear_busy: got %b want 0", clear_busy); end
        n_cmp++; if (vga_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_vga_rvalid: got %b want 0", vga_rvalid); end
        n_cmp++; if (game_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_game_rvalid: got %b want 0", game_rvalid); end
        n_cmp++; if (game_starved !== 1'b0) begin n_bad++; $display("FAIL rst_starved: got %b want 0", game_starved); end
        n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_bad++; $display("FAIL rst_mem_en_we: got %b want 00", {mem_en, mem_we}); end
        n_cmp++; if (mem_addr !== 10'h000) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 000", mem_addr); end
        n_cmp++; if (vga_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_vga_rdata: got %h want 00", vga_rdata); end
        n_cmp++; if (game_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_game_rdata: got %h want 00", game_rdata); end
    endtask

    task automatic test_game_rw();
        @(negedge clk);
        game_req = 1'b1; game_we = 1'b1; game_addr = 10'h123; game_wdata = 8'hA5;
        #1;
        n_cmp++; if (game_gnt !== 1'b1) begin n_bad++; $display("FAIL rw_wr_gnt: got %b want 1", game_gnt); end
        n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_bad++; $display("FAIL rw_wr_en_we: got %b want 11", {mem_en, mem_we}); end
        n_cmp++; if (mem_addr !== 10'h123) begin n_bad++; $display("FAIL rw_wr_addr: got %h want 123", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'hA5) begin n_bad++; $display("FAIL rw_wr_data: got %h want a5", mem_wdata); end
        model_mem[10'h123] = 8'hA5;
        @(negedge clk);
        game_we = 1'b0;
        #1;
        n_cmp++; if (game_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_wr_no_rvalid: got %b want 0", game_rvalid); end
        n_cmp++; if (game_gnt !== 1'b1) begin n_bad++; $display("FAIL rw_rd_gnt: got %b want 1", game_gnt); end
        @(posedge clk); #1;
        n_cmp++; if (game_rvalid !== 1'b1) begin n_bad++; $display("FAIL rw_rd_rvalid: got %b want 1", game_rvalid); end
        n_cmp++; if (game_rdata !== 8'hA5) begin n_bad++; $display("FAIL rw_rd_data: got %h want a5", game_rdata); end
        n_cmp++; if (vga_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_vga_rvalid: got %b want 0", vga_rvalid); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_vga_priority();
        game_req = 1'b1; game_we = 1'b1; game_addr = 10'h010; game_wdata = 8'hC3;
        model_mem[10'h010] = 8'hC3;
        @(negedge clk);
        vga_re = 1'b1; vga_raddr = 10'h010; game_we = 1'b0; game_addr = 10'h123;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++; if (game_gnt !== 1'b0) begin n_bad++; $display("FAIL prio_gnt_held c%0d: got %b want 0", i, game_gnt); end
            n_cmp++; if (mem_addr !== 10'h010) begin n_bad++; $display("FAIL prio_addr c%0d: got %h want 010", i, mem_addr); end
            @(posedge clk); #1;
            n_cmp++; if (vga_rvalid !== 1'b1) begin n_bad++; $display("FAIL prio_vga_rvalid c%0d: got %b want 1", i, vga_rvalid); end
            n_cmp++; if (vga_rdata !== model_mem[10'h010]) begin n_bad++; $display("FAIL prio_vga_rdata c%0d: got %h want %h", i, vga_rdata, model_mem[10'h010]); end
        end
        @(negedge clk);
        vga_re = 1'b0;
        #1;
        n_cmp++; if (game_gnt !== 1'b1) begin n_bad++; $display("FAIL prio_gnt_release: got %b want 1", game_gnt); end
        @(posedge clk); #1;
        n_cmp++; if (game_rvalid !== 1'b1) begin n_bad++; $display("FAIL prio_game_rvalid: got %b want 1", game_rvalid); end
        n_cmp++; if (game_rdata !== model_mem[10'h123]) begin n_bad++; $display("FAIL prio_game_rdata: got %h want %h", game_rdata, model_mem[10'h123]); end
        n_cmp++; if (vga_rvalid !== 1'b0) begin n_bad++; $display("FAIL prio_vga_rvalid_end: got %b want 0", vga_rvalid); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        logic              ev, eg, egnt;
        logic [DATA_W-1:0] evd, egd, last_v, last_g;
        bit                seen_v = 1'b0;
        bit                seen_g = 1'b0;
        last_v = '0; last_g = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            vga_re     = ($urandom_range(0, 2) == 0);
            vga_raddr  = ADDR_W'($urandom_range(0, 31));
            game_req   = 1'($urandom_range(0, 1));
            game_we    = 1'($urandom_range(0, 1));
            game_addr  = ADDR_W'($urandom_range(0, 31));
            game_wdata = DATA_W'($urandom);
            #1;
            egnt = game_req && !vga_re;
            n_cmp++; if (game_gnt !== egnt) begin n_bad++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, game_gnt, egnt); end
            n_cmp++; if (mem_en !== (vga_re || game_req)) begin n_bad++; $display("FAIL rnd_mem_en c%0d: got %b want %b", c, mem_en, vga_re || game_req); end
            if (vga_re) begin
                n_cmp++; if ({mem_we, mem_addr} !== {1'b0, vga_raddr}) begin n_bad++; $display("FAIL rnd_vga_port c%0d: got %b/%h want 0/%h", c, mem_we, mem_addr, vga_raddr); end
            end else if (egnt) begin
                n_cmp++; if ({mem_we, mem_addr} !== {game_we, game_addr}) begin n_bad++; $display("FAIL rnd_game_port c%0d: got %b/%h want %b/%h", c, mem_we, mem_addr, game_we, game_addr); end
                if (game_we) begin
                    n_cmp++; if (mem_wdata !== game_wdata) begin n_bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, game_wdata); end
                end
            end
            ev  = vga_re;
            evd = model_mem[vga_raddr];
            eg  = egnt && !game_we;
            egd = model_mem[game_addr];
            if (egnt && game_we) model_mem[game_addr] = game_wdata;
            @(posedge clk); #1;
            n_cmp++; if (vga_rvalid !== ev) begin n_bad++; $display("FAIL rnd_vga_rvalid c%0d: got %b want %b", c, vga_rvalid, ev); end
            n_cmp++; if (game_rvalid !== eg) begin n_bad++; $display("FAIL rnd_game_rvalid c%0d: got %b want %b", c, game_rvalid, eg); end
            if (ev) begin
                last_v = evd; seen_v = 1'b1;
            end
            if (seen_v) begin
                n_cmp++; if (vga_rdata !== last_v) begin n_bad++; $display("FAIL rnd_vga_rdata c%0d: got %h want %h", c, vga_rdata, last_v); end
            end
            if (eg) begin
                last_g = egd; seen_g = 1'b1;
            end
            if (seen_g) begin
                n_cmp++; if (game_rdata !== last_g) begin n_bad++; $display("FAIL rnd_game_rdata c%0d: got %h want %h", c, game_rdata, last_g); end
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_clear();
        int busy = 0;
        int bad_addr = 0;
        int gnts = 0;
        @(negedge clk);
        clear_start = 1'b1; clear_value = 8'h00;
        @(negedge clk);
        clear_start = 1'b0; game_req = 1'b1; game_we = 1'b0; game_addr = 10'h3FF;
        while (clear_busy && busy < 3000) begin
            clear_start = (busy == 500);
            clear_value = (busy == 500) ? 8'hFF : 8'h00;
            #1;
            if (mem_addr !== ADDR_W'(busy) || mem_we !== 1'b1 || mem_wdata !== 8'h00) bad_addr++;
            if (game_gnt) gnts++;
            busy++;
            @(negedge clk);
        end
        clear_start = 1'b0;
        #1;
        n_cmp++; if (busy != 1024) begin n_bad++; $display("FAIL clr_busy_len: got %0d want 1024", busy); end
        n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL clr_sweep_writes: got %0d bad cycles want 0", bad_addr); end
        n_cmp++; if (gnts != 0) begin n_bad++; $display("FAIL clr_gnt_during: got %0d want 0", gnts); end
        n_cmp++; if (game_gnt !== 1'b1) begin n_bad++; $display("FAIL clr_gnt_after: got %b want 1", game_gnt); end
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
        @(posedge clk); #1;
        n_cmp++; if ({game_rvalid, game_rdata} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL clr_read_3ff: got %b/%h want 1/00", game_rvalid, game_rdata); end
        @(negedge clk);
        game_addr = 10'h000;
        @(posedge clk); #1;
        n_cmp++; if ({game_rvalid, game_rdata} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL clr_read_000: got %b/%h want 1/00", game_rvalid, game_rdata); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_clear_vga();
        int                busy = 0;
        int                used = 0;
        int                written = 0;
        logic [DATA_W-1:0] v, exp_d;
        logic [ADDR_W-1:0] a;
        logic              do_v;
        v = DATA_W'($urandom_range(1, 255));
        @(negedge clk);
        clear_start = 1'b1; clear_value = v;
        @(negedge clk);
        clear_start = 1'b0; clear_value = ~v;
        while (clear_busy && busy < 3000) begin
            do_v = (used < 100) && ($urandom_range(0, 3) == 0);
            a = ADDR_W'($urandom);
            vga_re = do_v; vga_raddr = a;
            exp_d = (int'(a) < written) ? v : model_mem[a];
            @(posedge clk); #1;
            if (do_v) begin
                used++;
                n_cmp++; if ({vga_rvalid, vga_rdata} !== {1'b1, exp_d}) begin n_bad++; $display("FAIL clrv_vga_read a=%h: got %b/%h want 1/%h", a, vga_rvalid, vga_rdata, exp_d); end
            end else begin
                written++;
            end
            busy++;
            @(negedge clk);
        end
        vga_re = 1'b0;
        n_cmp++; if (busy != 1024 + used) begin n_bad++; $display("FAIL clrv_busy_len: got %0d want %0d", busy, 1024 + used); end
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = v;
        a = ADDR_W'($urandom);
        vga_re = 1'b1; vga_raddr = a;
        @(posedge clk); #1;
        n_cmp++; if (vga_rdata !== v) begin n_bad++; $display("FAIL clrv_fill_value: got %h want %h", vga_rdata, v); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_starve();
        bit gnt_seen = 1'b0;
        @(negedge clk);
        vga_re = 1'b1; vga_raddr = 10'h010; game_req = 1'b1; game_we = 1'b0; game_addr = 10'h050;
        for (int c = 1; c <= int'(STARVE_LIMIT); c++) begin
            starve_clr = (c == int'(STARVE_LIMIT));
            #1;
            if (game_gnt) gnt_seen = 1'b1;
            @(negedge clk);
            if (c == int'(STARVE_LIMIT) - 1) begin
                n_cmp++; if (game_starved !== 1'b0) begin n_bad++; $display("FAIL stv_early: got %b want 0", game_starved); end
            end
        end
        starve_clr = 1'b0;
        n_cmp++; if (gnt_seen) begin n_bad++; $display("FAIL stv_gnt_under_vga: got 1 want 0"); end
        n_cmp++; if (game_starved !== 1'b1) begin n_bad++; $display("FAIL stv_set_wins: got %b want 1", game_starved); end
        vga_re = 1'b0;
        #1;
        n_cmp++; if (game_gnt !== 1'b1) begin n_bad++; $display("FAIL stv_gnt: got %b want 1", game_gnt); end
        @(posedge clk); #1;
        n_cmp++; if (game_starved !== 1'b1) begin n_bad++; $display("FAIL stv_sticky: got %b want 1", game_starved); end
        n_cmp++; if ({game_rvalid, game_rdata} !== {1'b1, model_mem[10'h050]}) begin n_bad++; $display("FAIL stv_read: got %b/%h want 1/%h", game_rvalid, game_rdata, model_mem[10'h050]); end
        @(negedge clk);
        game_req = 1'b0; starve_clr = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (game_starved !== 1'b0) begin n_bad++; $display("FAIL stv_clear: got %b want 0", game_starved); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int i = 0;
        int busy = 0;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        clear_start = 1'b1; clear_value = 8'h77;
        @(negedge clk);
        clear_start = 1'b0;
        while (clear_busy && i < 'h200) begin
            i++;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (mem_addr !== 10'h200) begin n_bad++; $display("FAIL rmc_ptr: got %h want 200", mem_addr); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rmc_busy: got %b want 0", clear_busy); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rmc_mem_en: got %b want 0", mem_en); end
        clear_start = 1'b1; clear_value = 8'h3C;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        n_cmp++; if ({clear_busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h000, 8'h3C}) begin n_bad++; $display("FAIL rmc_restart: got %b/%b/%h/%h want 1/1/000/3c", clear_busy, mem_we, mem_addr, mem_wdata); end
        while (clear_busy && busy < 3000) begin
            busy++;
            @(negedge clk);
        end
        n_cmp++; if (busy != 1024) begin n_bad++; $display("FAIL rmc_busy_len: got %0d want 1024", busy); end
        for (int k = 0; k < int'(DEPTH); k++) model_mem[k] = 8'h3C;
        a = ADDR_W'($urandom);
        vga_re = 1'b1; vga_raddr = a;
        @(posedge clk); #1;
        n_cmp++; if (vga_rdata !== model_mem[a]) begin n_bad++; $display("FAIL rmc_fill: got %h want %h", vga_rdata, model_mem[a]); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
        test_reset();
        test_game_rw();
        test_vga_priority();
        test_random();
        test_clear();
        test_clear_vga();
        test_starve();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
